// File: rtl/sp_ram_be_clr_pkg.sv
`default_nettype none
// ============================================================================
// Module : sp_ram_pkg
// Brief  : Shared types, constants and byte-lane helpers for sp_ram_be_clr.
// Rev    : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

  // Even parity: the stored bit makes the 9-bit lane XOR to zero.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_be_clr_if.sv
`default_nettype none
// ============================================================================
// Module : sp_ram_be_clr_if
// Brief  : Access/clear bus for sp_ram_be_clr; Parity_Err under SP_RAM_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
interface sp_ram_be_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  Req;
  logic                  WE;
  logic [NB-1:0]         Byte_En;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data;
  logic                  Clear_Req;
  logic                  Ready;
  logic [DATA_WIDTH-1:0] Output;
  logic                  Out_Valid;
  logic                  Busy;
`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0]         Parity_Err;

  modport master (
    output Req, WE, Byte_En, Address, Data, Clear_Req,
    input  Ready, Output, Out_Valid, Busy, Parity_Err
  );
  modport slave (
    input  Req, WE, Byte_En, Address, Data, Clear_Req,
    output Ready, Output, Out_Valid, Busy, Parity_Err
  );
`else
  modport master (
    output Req, WE, Byte_En, Address, Data, Clear_Req,
    input  Ready, Output, Out_Valid, Busy
  );
  modport slave (
    input  Req, WE, Byte_En, Address, Data, Clear_Req,
    output Ready, Output, Out_Valid, Busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sp_ram_be_clr_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sp_ram_clear_ctrl
// Brief  : CLEAR/IDLE state machine, zero-fill sweep counter, Ready/Busy decode.
// Rev    : 1.0 - initial release
// ============================================================================
module sp_ram_clear_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear_req_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  sweep_en_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o
);

  localparam int                DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_IDLE;
      end
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A clear request wins over a same-cycle access, so Ready drops at once.
  assign ready_o      = (state_q == ST_IDLE) && !clear_req_i;
  assign busy_o       = (state_q == ST_CLEAR);
  assign sweep_en_o   = (state_q == ST_CLEAR);
  assign sweep_addr_o = cnt_q[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module : sp_ram_be_clr
// Brief  : Single-port RAM, byte enables, registered read, zero-fill engine.
//          Optional per-byte even parity when SP_RAM_PARITY_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module sp_ram_be_clr
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            CLK,
  input  logic            RST,
  sp_ram_be_clr_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SP_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = NB * LANE_W;

  logic                  w_ready;
  logic                  w_busy;
  logic                  w_sweep_en;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic                  w_accept;
  logic [MEM_W-1:0]      w_old_word;
  logic [MEM_W-1:0]      w_new_word;
  logic [MEM_W-1:0]      w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [MEM_W-1:0]      w_mem_wdata;

  logic [MEM_W-1:0]      mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  sp_ram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .CLK          (CLK),
    .RST          (RST),
    .clear_req_i  (bus.Clear_Req),
    .ready_o      (w_ready),
    .busy_o       (w_busy),
    .sweep_en_o   (w_sweep_en),
    .sweep_addr_o (w_sweep_addr)
  );

  assign bus.Ready = w_ready;
  assign bus.Busy  = w_busy;
  assign w_accept  = bus.Req && w_ready;
  assign w_old_word = mem_q[bus.Address];

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] w_rd_perr;
  logic [NB-1:0] perr_q;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_new_word[i*LANE_W +: 8] = byte_merge(w_old_word[i*LANE_W +: 8],
                                                  bus.Data[i*8 +: 8],
                                                  bus.Byte_En[i]);
    assign w_rd_data[i*8 +: 8] = w_rd_word[i*LANE_W +: 8];
`ifdef SP_RAM_PARITY_EN
    // Disabled lanes keep their stored parity, so corruption stays visible.
    assign w_new_word[i*LANE_W + 8] = bus.Byte_En[i] ? even_parity(bus.Data[i*8 +: 8])
                                                     : w_old_word[i*LANE_W + 8];
    assign w_rd_perr[i] = ^w_rd_word[i*LANE_W +: LANE_W];
`endif
  end

  assign w_rd_word = ((RDW_MODE == RDW_WRITE_FIRST) && bus.WE) ? w_new_word : w_old_word;

  // RST gating keeps the array untouched while reset is held.
  assign w_mem_we    = RST && (w_sweep_en || (w_accept && bus.WE));
  assign w_mem_addr  = w_sweep_en ? w_sweep_addr : bus.Address;
  assign w_mem_wdata = w_sweep_en ? '0 : w_new_word;

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      mem_q[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= w_accept;
      if (w_accept) begin
        rd_data_q <= w_rd_data;
      end
    end
  end

`ifdef SP_RAM_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perr_q <= '0;
    end else if (w_accept) begin
      perr_q <= w_rd_perr;
    end
  end
  assign bus.Parity_Err = perr_q;
`endif

  assign bus.Output    = rd_data_q;
  assign bus.Out_Valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module : tb_sp_ram_be_clr
// Brief  : Scoreboard bench; drives a read-first and a write-first instance
//          with identical stimulus. Parity case under SP_RAM_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_be_clr;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sp_ram_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus0 ();
  sp_ram_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus1 ();

  assign bus1.Req       = bus0.Req;
  assign bus1.WE        = bus0.WE;
  assign bus1.Byte_En   = bus0.Byte_En;
  assign bus1.Address   = bus0.Address;
  assign bus1.Data      = bus0.Data;
  assign bus1.Clear_Req = bus0.Clear_Req;

  sp_ram_be_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus0.slave)
  );

  sp_ram_be_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus1.slave)
  );

  typedef struct packed {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  ep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Monitor: every Out_Valid pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus0.Out_Valid || bus1.Out_Valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(bus0.Out_Valid) | 64'(bus1.Out_Valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_rf", 64'(bus0.Out_Valid), 1);
        check("valid_wf", 64'(bus1.Out_Valid), 1);
        check("out_rf", 64'(bus0.Output), 64'(e.e0));
        check("out_wf", 64'(bus1.Output), 64'(e.e1));
`ifdef SP_RAM_PARITY_EN
        check("perr_rf", 64'(bus0.Parity_Err), 64'(e.ep));
        check("perr_wf", 64'(bus1.Parity_Err), 64'(e.ep));
`endif
      end
    end
  end

  task automatic access(input logic we, input logic [5:0] addr, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [3:0] ep);
    exp_t e;
    bus0.Req     = 1'b1;
    bus0.WE      = we;
    bus0.Address = addr;
    bus0.Data    = d;
    bus0.Byte_En = be;
    #1;
    check("ready_accept", {62'b0, bus0.Ready, bus1.Ready}, 64'h3);
    e.e0 = e0;
    e.e1 = e1;
    e.ep = ep;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus0.Req = 1'b0;
    bus0.WE  = 1'b0;
  endtask

  task automatic count_busy(input int clr_at, input int req_at, output int n);
    logic ready_seen;
    ready_seen = 1'b0;
    n = 0;
    while (bus0.Busy && n < 200) begin
      bus0.Clear_Req = (n == clr_at);
      bus0.Req       = (n == req_at);
      #1;
      if (bus0.Ready || bus1.Ready) ready_seen = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    bus0.Clear_Req = 1'b0;
    bus0.Req       = 1'b0;
    check("ready_low_in_clear", 64'(ready_seen), 0);
    check("busy_wf_done", 64'(bus1.Busy), 0);
    check("ready_after_clear", 64'(bus0.Ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    bus0.Req       = 1'b0;
    bus0.WE        = 1'b0;
    bus0.Byte_En   = '0;
    bus0.Address   = '0;
    bus0.Data      = '0;
    bus0.Clear_Req = 1'b0;

    // Reset values and the power-up sweep.
    repeat (3) @(posedge clk);
    #1;
    check("rst_output", 64'(bus0.Output), 0);
    check("rst_valid", 64'(bus0.Out_Valid), 0);
    check("rst_busy", 64'(bus0.Busy), 1);
    check("rst_ready", 64'(bus0.Ready), 0);
`ifdef SP_RAM_PARITY_EN
    check("rst_perr", 64'(bus0.Parity_Err), 0);
`endif
    rst_n = 1'b1;
    count_busy(-1, -1, n);
    check("sweep_len_init", 64'(n), 64);
    for (int a = 0; a < 64; a++) begin
      access(1'b0, 6'(a), 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    end

    // Full then partial write, read back merged word.
    access(1'b1, 6'd5, 32'hAABBCCDD, 4'b1111, 32'h00000000, 32'hAABBCCDD, 4'h0);
    access(1'b1, 6'd5, 32'h11223344, 4'b0101, 32'hAABBCCDD, 32'hAA22CC44, 4'h0);
    access(1'b0, 6'd5, 32'h0,        4'b0000, 32'hAA22CC44, 32'hAA22CC44, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("output_hold", 64'(bus0.Output), 64'hAA22CC44);

    // Read-during-write mode and the empty byte mask.
    access(1'b1, 6'd9, 32'hFFFFFFFF, 4'b1111, 32'h00000000, 32'hFFFFFFFF, 4'h0);
    access(1'b0, 6'd9, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
    access(1'b1, 6'd9, 32'h00000000, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
    access(1'b0, 6'd9, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);

`ifdef SP_RAM_PARITY_EN
    access(1'b1, 6'd3, 32'h01020304, 4'b1111, 32'h00000000, 32'h01020304, 4'h0);
    @(posedge clk);
    #1;
    dut0.mem_q[3] = dut0.mem_q[3] ^ (36'd1 << 18);
    dut1.mem_q[3] = dut1.mem_q[3] ^ (36'd1 << 18);
    access(1'b0, 6'd3, 32'h0, 4'b0000, 32'h01030304, 32'h01030304, 4'b0100);
`endif

    // Clear request beats a same-cycle write; mid-sweep clear and req ignored.
    access(1'b1, 6'd12, 32'hDEADBEEF, 4'b1111, 32'h00000000, 32'hDEADBEEF, 4'h0);
    bus0.Clear_Req = 1'b1;
    bus0.Req       = 1'b1;
    bus0.WE        = 1'b1;
    bus0.Address   = 6'd12;
    bus0.Data      = 32'h12345678;
    bus0.Byte_En   = 4'b1111;
    #1;
    check("ready_vs_clear", {62'b0, bus0.Ready, bus1.Ready}, 0);
    @(posedge clk);
    #1;
    bus0.Clear_Req = 1'b0;
    bus0.Req       = 1'b0;
    bus0.WE        = 1'b0;
    count_busy(10, 20, n);
    check("sweep_len_cmd", 64'(n), 64);
    access(1'b0, 6'd12, 32'h0, 4'b0000, 32'h0, 32'h0, 4'h0);
    access(1'b0, 6'd5,  32'h0, 4'b0000, 32'h0, 32'h0, 4'h0);

    // Reset 30 cycles into a sweep restarts it from address 0.
    access(1'b1, 6'd40, 32'h5A5A5A5A, 4'b1111, 32'h00000000, 32'h5A5A5A5A, 4'h0);
    access(1'b0, 6'd40, 32'h0,        4'b0000, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'h0);
    bus0.Clear_Req = 1'b1;
    @(posedge clk);
    #1;
    bus0.Clear_Req = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_output", 64'(bus0.Output), 0);
    check("midsweep_rst_busy", 64'(bus0.Busy), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy(-1, -1, n);
    check("sweep_len_restart", 64'(n), 64);
    access(1'b0, 6'd40, 32'h0, 4'b0000, 32'h0, 32'h0, 4'h0);
    access(1'b0, 6'd9,  32'h0, 4'b0000, 32'h0, 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
